// File: rtl/tholin_bus_ctrl.sv
// tholin_bus_ctrl: 32-bit request to 16-bit muxed address/data bus sequencer.
// Drives a two-phase address latch (le_hi, le_lo), then one or two halfword
// data phases with OEb / WEb_lo / WEb_hi, and returns a one-cycle response.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid/ready      request handshake (ready = idle)
//   req_addr/we/mask/wdata  byte address, direction, byte enables, write data
//   resp_valid/rdata     one-cycle completion pulse and read data
//   bus_out/bus_in       bus drive value / bus read value
//   bus_dir              1 = this block drives the bus
//   le_lo, le_hi         address latch enables
//   OEb, WEb_lo, WEb_hi  active-low output enable and byte write strobes
//
// Parameter WAIT_CYCLES: extra cycles each data phase is held.
// Optional macro BUSCTL_HI_SKIP_EN: skip the high address phase when the
// high address half already latched in the external latch is unchanged.

module tholin_bus_ctrl #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [15:0] bus_out,
  input  logic [15:0] bus_in,
  output logic        bus_dir,
  output logic        le_lo,
  output logic        le_hi,
  output logic        OEb,
  output logic        WEb_lo,
  output logic        WEb_hi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AHI,
    S_ALO,
    S_D0,
    S_ALO2,
    S_D1,
    S_NOP,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [15:0] bo;
    logic        dir;
    logic        le_lo;
    logic        le_hi;
    logic        oeb;
    logic        web_lo;
    logic        web_hi;
  } bus_t;

  localparam bus_t BUS_IDLE = '{
    bo:     16'h0000,
    dir:    1'b0,
    le_lo:  1'b0,
    le_hi:  1'b0,
    oeb:    1'b1,
    web_lo: 1'b1,
    web_hi: 1'b1
  };

  localparam int WW = (WAIT_CYCLES > 0) ?
                      $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WMAX = WW'(WAIT_CYCLES);

  // Address phase: drive an address half and pulse one latch enable.
  function automatic bus_t f_addr(
    input logic        hi,
    input logic [15:0] a
  );
    bus_t b;
    b     = BUS_IDLE;
    b.bo  = a;
    b.dir = 1'b1;
    if (hi) b.le_hi = 1'b1;
    else    b.le_lo = 1'b1;
    return b;
  endfunction

  // Data phase: reads release the bus and enable the device output;
  // writes drive the data half with per-byte strobes.
  function automatic bus_t f_data(
    input logic        we,
    input logic [1:0]  m,
    input logic [15:0] wd
  );
    bus_t b;
    b = BUS_IDLE;
    if (we) begin
      b.dir    = 1'b1;
      b.bo     = wd;
      b.web_lo = ~m[0];
      b.web_hi = ~m[1];
    end else begin
      b.oeb = 1'b0;
    end
    return b;
  endfunction

  state_t        r_state;
  bus_t          r_bus;
  logic          r_ready;
  logic          r_rv;
  logic [31:0]   r_resp;
  logic [31:0]   r_h;
  logic          r_we;
  logic [3:0]    r_mask;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [WW-1:0] r_wait;

  logic [31:0] w_h;
  logic [15:0] w_h_odd;
  logic [15:0] w_new_lo;
  logic        w_l_act;
  logic        w_rl;
  logic        w_ru;
  logic        w_last;
  logic        w_skip;
  logic        w_unused;

  assign w_h      = {1'b0, req_addr[31:2], 1'b0};
  assign w_l_act  = |req_mask[1:0];
  assign w_new_lo = w_l_act ? w_h[15:0] : {w_h[15:1], 1'b1};
  assign w_h_odd  = {r_h[15:1], 1'b1};
  assign w_rl     = |r_mask[1:0];
  assign w_ru     = |r_mask[3:2];
  assign w_last   = (r_wait == WMAX);
  assign w_unused = &{1'b0, req_addr[1:0]};

`ifdef BUSCTL_HI_SKIP_EN
  logic [15:0] r_hi_last;
  logic        r_hi_vld;
  assign w_skip = r_hi_vld && (r_hi_last == w_h[31:16]);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bus   <= BUS_IDLE;
      r_ready <= 1'b1;
      r_rv    <= 1'b0;
      r_resp  <= 32'h0;
      r_h     <= 32'h0;
      r_we    <= 1'b0;
      r_mask  <= 4'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_wait  <= '0;
`ifdef BUSCTL_HI_SKIP_EN
      r_hi_last <= 16'h0;
      r_hi_vld  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_h     <= w_h;
            r_we    <= req_we;
            r_mask  <= req_mask;
            r_wdata <= req_wdata;
            r_rdata <= 32'h0;
            r_wait  <= '0;
            r_ready <= 1'b0;
            if (req_mask == 4'h0) begin
              // empty request: one quiet slot, then respond
              r_state <= S_NOP;
            end else if (w_skip) begin
              r_state <= S_ALO;
              r_bus   <= f_addr(1'b0, w_new_lo);
            end else begin
              r_state <= S_AHI;
              r_bus   <= f_addr(1'b1, w_h[31:16]);
`ifdef BUSCTL_HI_SKIP_EN
              r_hi_last <= w_h[31:16];
              r_hi_vld  <= 1'b1;
`endif
            end
          end
        end
        S_AHI: begin
          r_state <= S_ALO;
          r_bus   <= f_addr(1'b0,
                     w_rl ? r_h[15:0] : w_h_odd);
        end
        S_ALO: begin
          r_wait <= '0;
          if (w_rl) begin
            r_state <= S_D0;
            r_bus   <= f_data(r_we, r_mask[1:0],
                              r_wdata[15:0]);
          end else begin
            r_state <= S_D1;
            r_bus   <= f_data(r_we, r_mask[3:2],
                              r_wdata[31:16]);
          end
        end
        S_D0: begin
          if (!w_last) begin
            r_wait <= r_wait + 1'b1;
          end else begin
            if (!r_we) r_rdata[15:0] <= bus_in;
            if (w_ru) begin
              r_state <= S_ALO2;
              r_bus   <= f_addr(1'b0, w_h_odd);
            end else begin
              r_state <= S_RESP;
              r_bus   <= BUS_IDLE;
              r_rv    <= 1'b1;
              r_resp  <= r_we ? 32'h0 :
                         {16'h0, bus_in};
            end
          end
        end
        S_ALO2: begin
          r_wait  <= '0;
          r_state <= S_D1;
          r_bus   <= f_data(r_we, r_mask[3:2],
                            r_wdata[31:16]);
        end
        S_D1: begin
          if (!w_last) begin
            r_wait <= r_wait + 1'b1;
          end else begin
            if (!r_we) r_rdata[31:16] <= bus_in;
            r_state <= S_RESP;
            r_bus   <= BUS_IDLE;
            r_rv    <= 1'b1;
            r_resp  <= r_we ? 32'h0 :
                       {bus_in, r_rdata[15:0]};
          end
        end
        S_NOP: begin
          r_state <= S_RESP;
          r_bus   <= BUS_IDLE;
          r_rv    <= 1'b1;
          r_resp  <= 32'h0;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_rv    <= 1'b0;
          r_resp  <= 32'h0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_bus   <= BUS_IDLE;
          r_rv    <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_rv;
  assign resp_rdata = r_resp;
  assign bus_out    = r_bus.bo;
  assign bus_dir    = r_bus.dir;
  assign le_lo      = r_bus.le_lo;
  assign le_hi      = r_bus.le_hi;
  assign OEb        = r_bus.oeb;
  assign WEb_lo     = r_bus.web_lo;
  assign WEb_hi     = r_bus.web_hi;

endmodule

// File: tb/tb_tholin_bus_ctrl.sv
// Directed bench for tholin_bus_ctrl: one DUT with WAIT_CYCLES=0 and one
// with WAIT_CYCLES=2 share the request inputs; per-cycle traces are compared.

module tb_tholin_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic [15:0] bus_in;

  logic        a_rdy, a_rv, a_dir, a_lel, a_leh, a_oeb, a_wl, a_wh;
  logic [31:0] a_rd;
  logic [15:0] a_bo;
  logic        b_rdy, b_rv, b_dir, b_lel, b_leh, b_oeb, b_wl, b_wh;
  logic [31:0] b_rd;
  logic [15:0] b_bo;

  always #5 clk = ~clk;

  tholin_bus_ctrl #(.WAIT_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(a_rdy),
    .req_addr(req_addr), .req_we(req_we),
    .req_mask(req_mask), .req_wdata(req_wdata),
    .resp_valid(a_rv), .resp_rdata(a_rd),
    .bus_out(a_bo), .bus_in(bus_in), .bus_dir(a_dir),
    .le_lo(a_lel), .le_hi(a_leh), .OEb(a_oeb),
    .WEb_lo(a_wl), .WEb_hi(a_wh)
  );

  tholin_bus_ctrl #(.WAIT_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(b_rdy),
    .req_addr(req_addr), .req_we(req_we),
    .req_mask(req_mask), .req_wdata(req_wdata),
    .resp_valid(b_rv), .resp_rdata(b_rd),
    .bus_out(b_bo), .bus_in(bus_in), .bus_dir(b_dir),
    .le_lo(b_lel), .le_hi(b_leh), .OEb(b_oeb),
    .WEb_lo(b_wl), .WEb_hi(b_wh)
  );

  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic [15:0] bo;
    logic        dir;
    logic        lel;
    logic        leh;
    logic        oeb;
    logic        wl;
    logic        wh;
  } snap_t;

  snap_t       ta [0:15];
  snap_t       tbb[0:15];
  snap_t       ea [0:15];
  snap_t       eb [0:15];
  logic [15:0] bin[0:15];
  snap_t       msk;
  int          total = 0;
  int          bad = 0;

  function automatic snap_t S(
    input logic rdy, input logic rv,
    input logic [31:0] rd, input logic [15:0] bo,
    input logic dir, input logic lel, input logic leh,
    input logic oeb, input logic wl, input logic wh
  );
    snap_t s;
    s = '{rdy, rv, rd, bo, dir, lel, leh, oeb, wl, wh};
    return s;
  endfunction

  function automatic snap_t idl(input logic rdy);
    return S(rdy, 0, 0, 0, 0, 0, 0, 1, 1, 1);
  endfunction
  function automatic snap_t ahi(input logic [15:0] bo);
    return S(0, 0, 0, bo, 1, 0, 1, 1, 1, 1);
  endfunction
  function automatic snap_t alo(input logic [15:0] bo);
    return S(0, 0, 0, bo, 1, 1, 0, 1, 1, 1);
  endfunction
  function automatic snap_t rdp();
    return S(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
  endfunction
  function automatic snap_t wrp(input logic [15:0] bo,
                                input logic wl, input logic wh);
    return S(0, 0, 0, bo, 1, 0, 0, 1, wl, wh);
  endfunction
  function automatic snap_t rsp(input logic [31:0] rd);
    return S(0, 1, rd, 0, 0, 0, 0, 1, 1, 1);
  endfunction

  // rdata only meaningful with resp_valid; bus_out unspecified while OEb low
  function automatic snap_t mk_mask(input snap_t e);
    snap_t m;
    m = '1;
    if (!e.rv) m.rd = '0;
    if (!e.oeb) m.bo = '0;
    return m;
  endfunction

  function automatic snap_t snap_a();
    return S(a_rdy, a_rv, a_rd, a_bo, a_dir,
             a_lel, a_leh, a_oeb, a_wl, a_wh);
  endfunction
  function automatic snap_t snap_b();
    return S(b_rdy, b_rv, b_rd, b_bo, b_dir,
             b_lel, b_leh, b_oeb, b_wl, b_wh);
  endfunction

  task automatic init_tables();
    for (int k = 0; k < 16; k++) begin
      bin[k] = 16'hA000 + 16'(k);
      ea[k]  = idl(1'b1);
      eb[k]  = idl(1'b1);
    end
  endtask

  // Called at posedge+1 with both DUTs idle; cycle 0 is the accept cycle.
  task automatic run(input logic [31:0] a, input logic [31:0] a2,
                     input logic we, input logic [3:0] m,
                     input logic [31:0] wd, input int drop_k);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_mask  = m;
    req_wdata = wd;
    bus_in    = bin[0];
    ta[0]     = snap_a();
    tbb[0]    = snap_b();
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) req_addr = a2;
      if (k == drop_k) req_valid = 1'b0;
      bus_in = bin[k];
      ta[k]  = snap_a();
      tbb[k] = snap_b();
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_we    = 1'b0;
    req_mask  = 4'h0;
    req_wdata = 32'h0;
    bus_in    = 16'h0;
    #2 rst_n = 1'b0;
    #2;
    total++;
    if (snap_a() !== idl(1'b1)) begin
      bad++;
      $display("FAIL reset_a got=%h want=%h", snap_a(), idl(1'b1));
    end
    total++;
    if (snap_b() !== idl(1'b1)) begin
      bad++;
      $display("FAIL reset_b got=%h want=%h", snap_b(), idl(1'b1));
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (snap_a() !== idl(1'b1)) begin
      bad++;
      $display("FAIL reset_rel got=%h want=%h", snap_a(), idl(1'b1));
    end
  endtask

  task automatic test_read_full();
    init_tables();
    bin[3] = 16'h5678;
    bin[5] = 16'h1234;
    ea[1] = ahi(16'h2000);
    ea[2] = alo(16'h0008);
    ea[3] = rdp();
    ea[4] = alo(16'h0009);
    ea[5] = rdp();
    ea[6] = rsp(32'h1234_5678);
    run(32'h4000_0010, 32'h4000_0010, 1'b0, 4'hF, 32'h0, 1);
    for (int k = 0; k < 12; k++) begin
      msk = mk_mask(ea[k]);
      total++;
      if ((ta[k] & msk) !== (ea[k] & msk)) begin
        bad++;
        $display("FAIL read_full k=%0d got=%h want=%h",
                 k, ta[k], ea[k]);
      end
    end
  endtask

  task automatic test_write_partial();
    init_tables();
    ea[1] = ahi(16'h0000);
    ea[2] = alo(16'h091A);
    ea[3] = wrp(16'hCCDD, 1'b1, 1'b0);
    ea[4] = alo(16'h091B);
    ea[5] = wrp(16'hAABB, 1'b0, 1'b1);
    ea[6] = rsp(32'h0);
    run(32'h0000_1234, 32'h0000_1234, 1'b1, 4'b0110,
        32'hAABB_CCDD, 1);
    for (int k = 0; k < 12; k++) begin
      msk = mk_mask(ea[k]);
      total++;
      if ((ta[k] & msk) !== (ea[k] & msk)) begin
        bad++;
        $display("FAIL write_part k=%0d got=%h want=%h",
                 k, ta[k], ea[k]);
      end
    end
  endtask

  task automatic test_wait_upper();
    init_tables();
    ea[1] = ahi(16'h4000);
    ea[2] = alo(16'h0003);
    ea[3] = rdp();
    ea[4] = rsp(32'hA003_0000);
    eb[1] = ahi(16'h4000);
    eb[2] = alo(16'h0003);
    eb[3] = rdp();
    eb[4] = rdp();
    eb[5] = rdp();
    eb[6] = rsp(32'hA005_0000);
    run(32'h8000_0004, 32'h8000_0004, 1'b0, 4'b1100, 32'h0, 1);
    for (int k = 0; k < 12; k++) begin
      msk = mk_mask(ea[k]);
      total++;
      if ((ta[k] & msk) !== (ea[k] & msk)) begin
        bad++;
        $display("FAIL upper_w0 k=%0d got=%h want=%h",
                 k, ta[k], ea[k]);
      end
      msk = mk_mask(eb[k]);
      total++;
      if ((tbb[k] & msk) !== (eb[k] & msk)) begin
        bad++;
        $display("FAIL upper_w2 k=%0d got=%h want=%h",
                 k, tbb[k], eb[k]);
      end
    end
  endtask

  task automatic test_mask0();
    init_tables();
    ea[1] = idl(1'b0);
    ea[2] = rsp(32'h0);
    eb[1] = idl(1'b0);
    eb[2] = rsp(32'h0);
    run(32'h1234_5678, 32'h1234_5678, 1'b1, 4'h0,
        32'hFFFF_FFFF, 1);
    for (int k = 0; k < 8; k++) begin
      msk = mk_mask(ea[k]);
      total++;
      if ((ta[k] & msk) !== (ea[k] & msk)) begin
        bad++;
        $display("FAIL mask0_a k=%0d got=%h want=%h",
                 k, ta[k], ea[k]);
      end
      msk = mk_mask(eb[k]);
      total++;
      if ((tbb[k] & msk) !== (eb[k] & msk)) begin
        bad++;
        $display("FAIL mask0_b k=%0d got=%h want=%h",
                 k, tbb[k], eb[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nrv;
    snap_t s;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0000;
    req_we    = 1'b1;
    req_mask  = 4'hF;
    req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s = snap_a();
    total++;
    if (s !== wrp(16'h5678, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL rmid_d0 got=%h want=%h",
               s, wrp(16'h5678, 1'b0, 1'b0));
    end
    #3 rst_n = 1'b0;
    #1;
    s = snap_a();
    total++;
    if (s !== idl(1'b1)) begin
      bad++;
      $display("FAIL rmid_async got=%h want=%h", s, idl(1'b1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    nrv = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (a_rv || b_rv || a_leh || b_leh) nrv++;
    end
    total++;
    if (nrv !== 0) begin
      bad++;
      $display("FAIL rmid_quiet got=%0d want=0", nrv);
    end
    test_read_full();
  endtask

  task automatic test_back_to_back();
    init_tables();
    ea[1]  = ahi(16'h0000);
    ea[2]  = alo(16'h0008);
    ea[3]  = rdp();
    ea[4]  = rsp(32'h0000_A003);
    ea[6]  = ahi(16'h0001);
    ea[7]  = alo(16'h0008);
    ea[8]  = rdp();
    ea[9]  = rsp(32'h0000_A008);
    run(32'h0000_0010, 32'h0002_0010, 1'b0, 4'b0011, 32'h0, 6);
    for (int k = 0; k < 14; k++) begin
      msk = mk_mask(ea[k]);
      total++;
      if ((ta[k] & msk) !== (ea[k] & msk)) begin
        bad++;
        $display("FAIL b2b k=%0d got=%h want=%h",
                 k, ta[k], ea[k]);
      end
    end
  endtask

  task automatic test_hi_skip();
    pulse_reset();
    init_tables();
    ea[1] = ahi(16'h2000);
    ea[2] = alo(16'h0000);
    ea[3] = rdp();
    ea[4] = rsp(32'h0000_A003);
    run(32'h4000_0000, 32'h4000_0000, 1'b0, 4'b0011, 32'h0, 1);
    for (int k = 0; k < 8; k++) begin
      msk = mk_mask(ea[k]);
      total++;
      if ((ta[k] & msk) !== (ea[k] & msk)) begin
        bad++;
        $display("FAIL skip_first k=%0d got=%h want=%h",
                 k, ta[k], ea[k]);
      end
    end
    init_tables();
`ifdef BUSCTL_HI_SKIP_EN
    ea[1] = alo(16'h0080);
    ea[2] = rdp();
    ea[3] = rsp(32'h0000_A002);
`else
    ea[1] = ahi(16'h2000);
    ea[2] = alo(16'h0080);
    ea[3] = rdp();
    ea[4] = rsp(32'h0000_A003);
`endif
    run(32'h4000_0100, 32'h4000_0100, 1'b0, 4'b0011, 32'h0, 1);
    for (int k = 0; k < 8; k++) begin
      msk = mk_mask(ea[k]);
      total++;
      if ((ta[k] & msk) !== (ea[k] & msk)) begin
        bad++;
        $display("FAIL skip_second k=%0d got=%h want=%h",
                 k, ta[k], ea[k]);
      end
    end
    pulse_reset();
    init_tables();
    ea[1] = ahi(16'h2000);
    ea[2] = alo(16'h0080);
    ea[3] = rdp();
    ea[4] = rsp(32'h0000_A003);
    run(32'h4000_0100, 32'h4000_0100, 1'b0, 4'b0011, 32'h0, 1);
    for (int k = 0; k < 8; k++) begin
      msk = mk_mask(ea[k]);
      total++;
      if ((ta[k] & msk) !== (ea[k] & msk)) begin
        bad++;
        $display("FAIL skip_after_rst k=%0d got=%h want=%h",
                 k, ta[k], ea[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_full();
    test_write_partial();
    test_wait_upper();
    test_mask0();
    test_reset_mid();
    test_back_to_back();
    test_hi_skip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
